phy_rx_deserializer: RTL
========================

Name: phy_rx_deserializer

Overview:
Receive-side counterpart of the PHY transmit path. It takes the single-bit serial stream produced by the transmitter and finds byte alignment by hunting for the COM symbol. It then regroups the recovered bytes round-robin into the four 8-bit lanes, each with its own valid flag. It sits between the serial link and the 4-lane receive logic and runs on one clock at the bit rate.

Parameters:
COM, 8'hBC, comma/idle symbol; the transmitter sends it for alignment and for any invalid lane slot.
SYNC_COUNT, 4, consecutive byte-aligned COMs required to declare lock (range 1..15).

Ports:
clk  input  1  bit-rate clock; all state updates on the rising edge.
reset_L  input  1  asynchronous, active-low reset.
serial_in  input  1  serial data, MSB of each byte first, one bit per clk.
out0  output  8  lane 0 byte of the last completed word.
out1  output  8  lane 1 byte.
out2  output  8  lane 2 byte.
out3  output  8  lane 3 byte.
valid0  output  1  lane 0 byte is data (not COM).
valid1  output  1  lane 1 valid.
valid2  output  1  lane 2 valid.
valid3  output  1  lane 3 valid.
word_valid  output  1  one-cycle pulse when out0..3 and valid0..3 update.
active  output  1  high while in LOCKED.

Behaviour:
- Clock and reset: one clock, clk. reset_L is asynchronous and active-low; asserting it clears all state immediately, mid-byte or mid-word included.
- Reset values: out0..3=0, valid0..3=0, word_valid=0, active=0, state=HUNT, shift register=0, bit_cnt=0, com_cnt=0, lane_ptr=0.
- Shift register: every cycle, sr <= {sr[6:0], serial_in}. nsr denotes that next value.
- HUNT state:
  - Compare nsr with COM every cycle (bit-level sliding search).
  - On a match: bit_cnt<=0, com_cnt<=1, go to SYNC (or straight to LOCKED if SYNC_COUNT==1).
- bit_cnt: 3-bit counter, counts 0..7 outside HUNT. The byte boundary is the cycle with bit_cnt==7; nsr is then the completed byte. bit_cnt wraps 7->0.
- SYNC state, at each byte boundary:
  - byte==COM: com_cnt++. When com_cnt+1==SYNC_COUNT, go to LOCKED with lane_ptr<=0 and active<=1 from the next cycle.
  - byte!=COM: com_cnt<=0, return to HUNT. Bit search restarts on the following cycle.
- LOCKED state, at each byte boundary:
  - The byte goes to lane slot lane_ptr: data stored = (byte==COM) ? 8'h00 : byte; lane valid = (byte!=COM).
  - lane_ptr increments, wrapping 3->0.
- Word publication:
  - When the lane_ptr==3 byte completes, out0..3 and valid0..3 are registered together from the three held slots plus the current byte.
  - word_valid pulses high for exactly that one cycle.
  - Outputs then hold until the next word.
- Latency: the last serial bit of lane 3 sampled on edge N; outputs and word_valid are visible after edge N+1.
- Training preamble: the first byte after the lock-completing COM is lane 0. The transmitter therefore sends at least SYNC_COUNT COMs, then lane-0-aligned words.
- Lock retention: lock is held until reset. A lane carrying COM is idle, not an error.
- Partial word at reset: discarded; no word_valid.
- Simultaneous events: a COM match on the same cycle as reset release is ignored.
- Width rules: all data is 8 bits; no arithmetic on data. com_cnt is 4 bits and saturates at SYNC_COUNT.

Decomposition:
- Shared package phy_pkg holds:
  - the COM constant (8'hBC), shared with the transmitter;
  - the state encoding HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2;
  - the lane-count constant 4.
- Sub-module phy_rx_s2p:
  - contains the shift register, bit_cnt, HUNT/SYNC/LOCKED FSM and com_cnt;
  - outputs byte[7:0], byte_strobe and active.
- The top level holds the lane_ptr distributor and the output registers.

Test Plan:
- Lock: reset, then 3 idle bits, then 4 x 8'hBC -> active rises 1 cycle after the 4th COM's last bit; before that, word_valid stays 0 and all outputs stay 0.
- Data: after lock, send FF,EE,DD,CC -> a single word_valid pulse; out0..3=FF,EE,DD,CC; valid0..3=1111; latency exactly 1 cycle after the last bit. Next send BB,AA,99,88 -> second pulse exactly 32 cycles later with those values.
- Idle lanes: after lock, send 55,55,77,BC -> out3=00, valid3=0, valid0..2=1; next BC,BC,77,BC -> only valid2=1, out2=77.
- Sync break: 2 COMs then 8'h12 -> returns to HUNT, active stays 0. A following bit-shifted (3-bit offset) run of 4 COMs locks correctly at the new boundary.
- Reset mid-word: assert reset_L low after 2 data bytes of a locked word -> all outputs clear immediately and active=0; no word_valid until a fresh preamble.
- Parameter: SYNC_COUNT=1 -> a single COM locks; first word FF,EE,DD,CC published correctly.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY constants: comma symbol, receive FSM encoding and lane count.
// The COM value must stay identical to the transmitter's.
package phy_pkg;

    localparam logic [7:0] COM       = 8'hBC;
    localparam int         NUM_LANES = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    // A lane slot carrying COM is idle: its data reads as zero.
    function automatic logic [7:0] lane_data(input logic [7:0] b);
        return (b == COM) ? 8'h00 : b;
    endfunction

endpackage

// File: rtl/phy_rx_s2p.sv
// Serial-to-byte front end: sliding COM search, byte alignment and lock FSM.
// Emits each aligned byte with a one-cycle strobe once locked.
module phy_rx_s2p
    import phy_pkg::*;
#(
    parameter int SYNC_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       i_serial,
    output logic [7:0] o_byte,
    output logic       o_byte_strobe,
    output logic       o_active,
    output logic [1:0] o_state
);

    localparam logic [3:0] SYNC_CNT4 = 4'(SYNC_COUNT);

    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_com_cnt;
    rx_state_t  r_state;
    logic [7:0] r_byte;
    logic       r_byte_strobe;
    logic       r_active;

    logic [7:0] w_nsr;
    logic       w_boundary;
    rx_state_t  w_state_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [3:0] w_com_cnt_nxt;
    logic       w_strobe_nxt;

    assign w_nsr      = {r_sr[6:0], i_serial};
    assign w_boundary = (r_bit_cnt == 3'd7);

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        w_com_cnt_nxt = r_com_cnt;
        w_strobe_nxt  = 1'b0;
        case (r_state)
            HUNT: begin
                // bit_cnt parks at 0 so the next cycle starts a fresh byte.
                w_bit_cnt_nxt = 3'd0;
                if (w_nsr == COM) begin
                    w_com_cnt_nxt = 4'd1;
                    if (SYNC_COUNT == 1) w_state_nxt = LOCKED;
                    else                 w_state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (w_boundary) begin
                    if (w_nsr == COM) begin
                        w_com_cnt_nxt = r_com_cnt + 4'd1;
                        if (r_com_cnt + 4'd1 == SYNC_CNT4) w_state_nxt = LOCKED;
                    end else begin
                        w_com_cnt_nxt = 4'd0;
                        w_state_nxt   = HUNT;
                    end
                end
            end
            LOCKED: begin
                w_strobe_nxt = w_boundary;
            end
            default: begin
                w_state_nxt   = HUNT;
                w_bit_cnt_nxt = 3'd0;
                w_com_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_sr          <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_com_cnt     <= 4'd0;
            r_state       <= HUNT;
            r_byte        <= 8'h00;
            r_byte_strobe <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_sr          <= w_nsr;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_com_cnt     <= w_com_cnt_nxt;
            r_state       <= w_state_nxt;
            r_byte_strobe <= w_strobe_nxt;
            r_active      <= (r_state == LOCKED);
            if (w_strobe_nxt) r_byte <= w_nsr;
        end
    end

    assign o_byte        = r_byte;
    assign o_byte_strobe = r_byte_strobe;
    assign o_active      = r_active;
    assign o_state       = r_state;

endmodule

// File: rtl/phy_rx_deserializer.sv
// Receive deserializer top: aligns the serial stream and distributes bytes
// round-robin into four lanes, publishing a full word at once.
module phy_rx_deserializer
    import phy_pkg::*;
#(
    parameter int SYNC_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       serial_in,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic       valid0,
    output logic       valid1,
    output logic       valid2,
    output logic       valid3,
    output logic       word_valid,
    output logic       active
);

    localparam logic [1:0] LANE_LAST = 2'(NUM_LANES - 1);

    logic [7:0] w_byte;
    logic       w_byte_strobe;
    logic [1:0] w_state;
    logic       w_take;
    logic [7:0] w_data;
    logic       w_valid;

    logic [1:0] r_lane_ptr;
    logic [7:0] r_slot0, r_slot1, r_slot2;
    logic [2:0] r_slot_v;
    logic [7:0] r_out0, r_out1, r_out2, r_out3;
    logic [3:0] r_valid;
    logic       r_word_valid;

    phy_rx_s2p #(
        .SYNC_COUNT(SYNC_COUNT)
    ) u_s2p (
        .clk          (clk),
        .reset_L      (reset_L),
        .i_serial     (serial_in),
        .o_byte       (w_byte),
        .o_byte_strobe(w_byte_strobe),
        .o_active     (active),
        .o_state      (w_state)
    );

    assign w_take  = w_byte_strobe && (w_state == LOCKED);
    assign w_data  = lane_data(w_byte);
    assign w_valid = (w_byte != COM);

    // Slots 0..2 are held privately; the lane-3 byte completes the word and
    // all four lanes move to the outputs in the same cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_lane_ptr   <= 2'd0;
            r_slot0      <= 8'h00;
            r_slot1      <= 8'h00;
            r_slot2      <= 8'h00;
            r_slot_v     <= 3'b000;
            r_out0       <= 8'h00;
            r_out1       <= 8'h00;
            r_out2       <= 8'h00;
            r_out3       <= 8'h00;
            r_valid      <= 4'b0000;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (w_take) begin
                r_lane_ptr <= r_lane_ptr + 2'd1;
                if (r_lane_ptr == LANE_LAST) begin
                    r_out0       <= r_slot0;
                    r_out1       <= r_slot1;
                    r_out2       <= r_slot2;
                    r_out3       <= w_data;
                    r_valid      <= {w_valid, r_slot_v};
                    r_word_valid <= 1'b1;
                end else begin
                    case (r_lane_ptr)
                        2'd0:    r_slot0 <= w_data;
                        2'd1:    r_slot1 <= w_data;
                        default: r_slot2 <= w_data;
                    endcase
                    r_slot_v[r_lane_ptr] <= w_valid;
                end
            end
        end
    end

    assign out0       = r_out0;
    assign out1       = r_out1;
    assign out2       = r_out2;
    assign out3       = r_out3;
    assign valid0     = r_valid[0];
    assign valid1     = r_valid[1];
    assign valid2     = r_valid[2];
    assign valid3     = r_valid[3];
    assign word_valid = r_word_valid;

endmodule
